pipe_drain: RTL

Terminal receiver for the stall-controlled double-buffered pipeline. The pipeline's last stage presents out_r/out_vld_r and has no accept, so this block must take every beat it is offered. It buffers those beats in a FIFO and re-presents them downstream on a valid/accept handshake. It raises a registered stall request early enough that in-flight beats still fit, and it keeps overflow and occupancy statistics.

---
 rtl/libv2_pkg.sv | 17 +
 rtl/drain_fifo_mem.sv | 33 +++
 rtl/pipe_drain.sv | 105 ++++++++++
 3 files changed

// File: rtl/libv2_pkg.sv
// ============================================================================
// Module : libv2_pkg
// Brief  : Shared helpers for the pipeline library (pointer/count widths).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package libv2_pkg;

    // Pointer and occupancy width: index bits plus one wrap bit.
    function automatic int clog2p1(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/drain_fifo_mem.sv
// ============================================================================
// Module : drain_fifo_mem
// Brief  : DEPTH x W register array, one write port, combinational read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drain_fifo_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [W-1:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [W-1:0]               rdata
);

    // Contents are deliberately not reset; validity is tracked by the pointers.
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pipe_drain.sv
// ============================================================================
// Module : pipe_drain
// Brief  : Pipeline terminal FIFO with early stall request, high-water mark
//          and sticky overflow flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_drain
    import libv2_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int SLACK = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [W-1:0]                  in,
    input  logic                          in_vld,
    output logic                          stall_r,
    output logic [W-1:0]                  out,
    output logic                          out_vld,
    input  logic                          out_accept,
    output logic [clog2p1(DEPTH)-1:0]     cnt_r,
    output logic [clog2p1(DEPTH)-1:0]     hwm_r,
    input  logic                          hwm_clr,
    output logic                          err_ovf_r,
    input  logic                          err_clr
);

    localparam int c_PW = clog2p1(DEPTH);
    localparam int c_AW = c_PW - 1;
    localparam logic [c_PW-1:0] c_ONE    = c_PW'(1);
    localparam logic [c_PW-1:0] c_THRESH = c_PW'(DEPTH - SLACK);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("pipe_drain: DEPTH must be a power of two and at least 4");
    end
    if ((SLACK < 1) || (SLACK >= DEPTH)) begin : g_chk_slack
        $error("pipe_drain: SLACK must satisfy 1 <= SLACK < DEPTH");
    end

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf;
    logic [c_PW-1:0] w_cnt_next;
    logic [c_PW-1:0] w_hwm_next;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign out_vld = ~w_empty;
    assign w_pop   = out_vld & out_accept;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign w_push  = in_vld & (~w_full | w_pop);
    assign w_ovf   = in_vld & w_full & ~w_pop;

    always_comb begin
        w_cnt_next = cnt_r;
        if (w_push) w_cnt_next = w_cnt_next + c_ONE;
        if (w_pop)  w_cnt_next = w_cnt_next - c_ONE;
    end

    always_comb begin
        w_hwm_next = hwm_r;
        if (hwm_clr || (w_cnt_next > hwm_r)) w_hwm_next = w_cnt_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            cnt_r     <= '0;
            hwm_r     <= '0;
            stall_r   <= 1'b0;
            err_ovf_r <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
            cnt_r     <= w_cnt_next;
            hwm_r     <= w_hwm_next;
            stall_r   <= (w_cnt_next >= c_THRESH);
            err_ovf_r <= (err_ovf_r & ~err_clr) | w_ovf;
        end
    end

    drain_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[c_AW-1:0]),
        .wdata (in),
        .raddr (r_rd_ptr[c_AW-1:0]),
        .rdata (out)
    );

endmodule

`default_nettype wire
